// File: rtl/alu_pkg.sv
// Shared opcode encoding, default widths and flag bit positions for alu_unit.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  localparam int DW_DEF = 3;
  localparam int OW_DEF = 5;

  localparam int FLAG_W     = 2;
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle for alu_unit; FLAGS exists only when ALU_FLAGS_EN is defined.
interface alu_if import alu_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int OW = OW_DEF
);

  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [2:0]    OP;
  logic [OW-1:0] ALU_OUT;
`ifdef ALU_FLAGS_EN
  logic [FLAG_W-1:0] FLAGS;
`endif

  modport master (
    output A, B, OP,
`ifdef ALU_FLAGS_EN
    input  FLAGS,
`endif
    input  ALU_OUT
  );

  modport slave (
    input  A, B, OP,
`ifdef ALU_FLAGS_EN
    output FLAGS,
`endif
    output ALU_OUT
  );

endinterface

// File: rtl/alu_datapath.sv
// Combinational f(OP, A, B); operands are zero-extended to OW and results wrap modulo 2^OW.
// Flag generation is compiled in only when ALU_FLAGS_EN is defined.
module alu_datapath import alu_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic [DW-1:0]     a,
  input  logic [DW-1:0]     b,
  input  logic [2:0]        op,
`ifdef ALU_FLAGS_EN
  output logic [FLAG_W-1:0] flags,
`endif
  output logic [OW-1:0]     res
);

  localparam logic [OW-1:0] OW_V = OW'(OW);

  logic [OW-1:0] a_ext;
  logic [OW-1:0] b_ext;

  assign a_ext = OW'(a);
  assign b_ext = OW'(b);

  always_comb begin
    res = '0;
    case (op_e'(op))
      OP_ADD: res = a_ext + b_ext;
      OP_SUB: res = a_ext - b_ext;
      OP_MUL: res = a_ext * b_ext;
      OP_AND: res = a_ext & b_ext;
      OP_OR:  res = a_ext | b_ext;
      OP_XOR: res = a_ext ^ b_ext;
      // Shift amounts of OW or more push every bit out of the result.
      OP_SHL: res = (b_ext >= OW_V) ? '0 : (a_ext << b_ext);
      OP_CMP: begin
        res[2] = (a > b);
        res[1] = (a == b);
        res[0] = (a < b);
      end
      default: res = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  localparam int PW = 2 * OW;

  logic [OW:0]   sum_w;
  logic [PW-1:0] prod_w;

  // Full-precision copies of ADD/MUL so overflow beyond OW bits is visible.
  assign sum_w  = {1'b0, a_ext} + {1'b0, b_ext};
  assign prod_w = PW'(a_ext) * PW'(b_ext);

  always_comb begin
    flags = '0;
    flags[FLAG_ZERO] = (res == '0);
    case (op_e'(op))
      OP_ADD:  flags[FLAG_CARRY] = ((sum_w >> OW) != '0);
      OP_MUL:  flags[FLAG_CARRY] = ((prod_w >> OW) != '0);
      OP_SUB:  flags[FLAG_CARRY] = (b > a);
      default: flags[FLAG_CARRY] = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/alu_unit.sv
// Registered 8-operation ALU: result of the operands sampled at one edge appears after it.
// Optional FLAGS output is enabled with the ALU_FLAGS_EN macro.
module alu_unit import alu_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);

  logic [OW-1:0] dp_res;
  logic [OW-1:0] alu_out_d;
  logic [OW-1:0] alu_out_q;
`ifdef ALU_FLAGS_EN
  logic [FLAG_W-1:0] dp_flags;
  logic [FLAG_W-1:0] flags_d;
  logic [FLAG_W-1:0] flags_q;
`endif

  alu_datapath #(
    .DW (DW),
    .OW (OW)
  ) u_datapath (
    .a     (bus.A),
    .b     (bus.B),
    .op    (bus.OP),
`ifdef ALU_FLAGS_EN
    .flags (dp_flags),
`endif
    .res   (dp_res)
  );

  always_comb begin
    alu_out_d = dp_res;
`ifdef ALU_FLAGS_EN
    flags_d   = dp_flags;
`endif
  end

  // Asynchronous clear discards whatever result was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= '0;
`ifdef ALU_FLAGS_EN
      flags_q   <= '0;
`endif
    end else begin
      alu_out_q <= alu_out_d;
`ifdef ALU_FLAGS_EN
      flags_q   <= flags_d;
`endif
    end
  end

  assign bus.ALU_OUT = alu_out_q;
`ifdef ALU_FLAGS_EN
  assign bus.FLAGS   = flags_q;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: driver pushes expected results, negedge monitor pops and compares.
module tb_alu_unit;
  import alu_pkg::*;

  localparam int DW = 3;
  localparam int OW = 5;

  typedef struct {
    logic [OW-1:0] out;
    logic [1:0]    flg;
    int            due;
    string         name;
  } exp_t;

  typedef struct {
    logic [2:0]    op;
    int            a;
    int            b;
    logic [OW-1:0] out;
    logic [1:0]    flg;
    string         name;
  } vec_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  exp_t q[$];

  alu_if #(.DW(DW), .OW(OW)) bus ();

  alu_unit #(.DW(DW), .OW(OW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model straight from the opcode definitions, using integer arithmetic.
  function automatic void model(input int op, input int a, input int b,
                                output logic [OW-1:0] o, output logic [1:0] f);
    int r;
    int m;
    m = 1 << OW;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = a * (2 ** b);
      default: r = (a > b ? 4 : 0) + (a == b ? 2 : 0) + (a < b ? 1 : 0);
    endcase
    o = OW'(((r % m) + m) % m);
    f[0] = (o == 0);
    f[1] = ((op == 0 || op == 2) && r > m - 1) || (op == 1 && b > a);
  endfunction

  task automatic issue(input logic [2:0] op, input int a, input int b,
                       input logic [OW-1:0] o, input logic [1:0] f, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    bus.OP = op;
    bus.A  = DW'(a);
    bus.B  = DW'(b);
    e.out  = o;
    e.flg  = f;
    e.due  = cyc + 1;
    e.name = name;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk({e.name, "_due"}, 32'(cyc), 32'(e.due));
      chk(e.name, 32'(bus.ALU_OUT), 32'(e.out));
`ifdef ALU_FLAGS_EN
      chk({e.name, "_flags"}, 32'(bus.FLAGS), 32'(e.flg));
`endif
    end
  end

  vec_t dir[$];

  initial begin
    logic [OW-1:0] mo;
    logic [1:0]    mf;
    int            ra;
    int            rb;
    int            rop;
    int            waited;
    total = 0;
    bad   = 0;

    dir = '{
      '{3'b000, 7, 4, 5'b01011, 2'b00, "sweep_add"},
      '{3'b001, 7, 4, 5'b00011, 2'b00, "sweep_sub"},
      '{3'b010, 7, 4, 5'b11100, 2'b00, "sweep_mul"},
      '{3'b011, 7, 4, 5'b00100, 2'b00, "sweep_and"},
      '{3'b100, 7, 4, 5'b00111, 2'b00, "sweep_or"},
      '{3'b101, 7, 4, 5'b00011, 2'b00, "sweep_xor"},
      '{3'b110, 7, 4, 5'b10000, 2'b00, "sweep_shl"},
      '{3'b111, 7, 4, 5'b00100, 2'b00, "sweep_cmp"},
      '{3'b001, 2, 5, 5'b11101, 2'b10, "sub_wrap"},
      '{3'b010, 7, 7, 5'b10001, 2'b10, "mul_trunc"},
      '{3'b111, 3, 3, 5'b00010, 2'b00, "cmp_eq"},
      '{3'b111, 1, 6, 5'b00001, 2'b00, "cmp_lt"},
      '{3'b110, 1, 3, 5'b01000, 2'b00, "shl_1_3"},
      '{3'b110, 5, 5, 5'b00000, 2'b01, "shl_out"},
      '{3'b011, 5, 2, 5'b00000, 2'b01, "and_zero"},
      '{3'b000, 7, 7, 5'b01110, 2'b00, "add_max"}
    };

    // Reset held while clocking with live operands.
    rst_n  = 1'b0;
    bus.A  = 3'd7;
    bus.B  = 3'd4;
    bus.OP = OP_ADD;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", 32'(bus.ALU_OUT), 32'd0);
`ifdef ALU_FLAGS_EN
      chk("rst_hold_flags", 32'(bus.FLAGS), 32'd0);
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b, dir[i].out, dir[i].flg, dir[i].name);

    // Asynchronous reset between edges must clear the output immediately.
    issue(OP_ADD, 7, 4, 5'b01011, 2'b00, "pre_async");
    @(posedge clk);
    @(negedge clk);
    #2;
    chk("async_before", 32'(bus.ALU_OUT), 32'd11);
    rst_n = 1'b0;
    #1;
    chk("async_drop", 32'(bus.ALU_OUT), 32'd0);
`ifdef ALU_FLAGS_EN
    chk("async_drop_flags", 32'(bus.FLAGS), 32'd0);
`endif
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("async_hold", 32'(bus.ALU_OUT), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      rop = int'($urandom_range(0, 7));
      ra  = int'($urandom_range(0, 7));
      rb  = int'($urandom_range(0, 7));
      model(rop, ra, rb, mo, mf);
      issue(3'(rop), ra, rb, mo, mf, "rand");
    end

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 3-bit-operand, 8-operation arithmetic/logic unit with a registered 5-bit result.
- Operands and opcode are sampled on every rising clock edge; the result appears one cycle later.
- Used as a leaf datapath block; no handshake, so it accepts a new operation every cycle.

Parameters:
- DW, 3, operand width (A, B); the fixed spec values below assume 3.
- OW, 5, result width; must be at least 2*DW-1 so the product of 7*4=28 fits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  DW  operand A, unsigned.
- B  input  DW  operand B, unsigned.
- OP  input  3  opcode.
- ALU_OUT  output  OW  registered result.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, ALU_OUT=0 immediately, regardless of clk. The first capture happens on the first rising clk edge after rst_n is released.
- Latency: ALU_OUT at edge N+1 equals f(OP, A, B) as sampled at edge N. Throughput is 1 operation per cycle. There is no enable; the register updates every cycle.
- Width rule: A and B are zero-extended to OW before any operation. All results are taken modulo 2^OW.
- Opcodes:
  - 000 ADD: A+B. Maximum is 14, so there is no overflow at OW=5.
  - 001 SUB: A-B, two's-complement, wraps modulo 32. For example, 2-5 gives 5'b11101.
  - 010 MUL: A*B, unsigned. Maximum is 49, truncated to 5 bits (49 gives 17).
  - 011 AND: bitwise A&B, zero-extended.
  - 100 OR: bitwise A|B, zero-extended.
  - 101 XOR: bitwise A^B, zero-extended.
  - 110 SHL: A<<B, logical. Bits shifted out above bit OW-1 are lost. A shift of B>=OW gives 0.
  - 111 CMP: result {2'b00, A>B, A==B, A<B}. Exactly one of the low three bits is 1.
- OP values with X/Z: no requirement. Every defined OP value has a defined result, so no default output is needed.
- Reset mid-operation: any pending result is discarded and ALU_OUT goes to 0. The operation in flight is not replayed.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined, add output FLAGS [1:0], registered alongside ALU_OUT with the same latency and reset value 0:
  - FLAGS[0] ZERO: the next ALU_OUT is 0.
  - FLAGS[1] CARRY: for ADD/MUL, the full-precision result exceeded 2^OW-1. For SUB, the borrow (B>A). For all other opcodes, 0.
- When undefined, the FLAGS port and its logic are absent, and ALU_OUT behaviour is unchanged.

Decomposition:
- Package alu_pkg holds:
  - the opcode enum: OP_ADD=3'b000, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_CMP=3'b111;
  - the DW/OW default constants;
  - the FLAGS bit indices.
- Sub-module alu_datapath: purely combinational, computing f(OP,A,B) (and the flags). alu_unit contains only the output register(s) and reset.

Test Plan:
- Hold rst_n=0, toggle clk, then drive A=7, B=4 -> ALU_OUT=0 throughout reset. Assert rst_n=0 asynchronously mid-cycle -> ALU_OUT drops to 0 without waiting for a clk edge.
- A=7, B=4, sweep OP 000..111 one per cycle -> ALU_OUT one cycle later = 01011, 00011, 11100, 00100, 00111, 00011, 10000, 00100.
- SUB A=2, B=5 -> 11101 (FLAGS=2'b10 with ALU_FLAGS_EN). MUL A=7, B=7 -> 10001 (CARRY=1).
- CMP: A=3, B=3 -> 00010; A=1, B=6 -> 00001. SHL A=1, B=3 -> 01000; A=5, B=5 -> 00000.
- Back-to-back changes every cycle with random A/B/OP for 1000 cycles -> ALU_OUT matches a reference model delayed by exactly one cycle.
- With ALU_FLAGS_EN: AND A=5, B=2 -> ALU_OUT=0, FLAGS[0]=1. ADD A=7, B=7 -> 01110, FLAGS=00.
